// File: rtl/router_fifo_pkt_if.sv
// Write/read/status bundle between a router FIFO and its writer/reader.
// The master drives data and requests; the slave (the FIFO) returns data and status.
interface router_fifo_pkt_if #(
    parameter int RAM_WIDTH = 8,
    parameter int ADDR_SIZE = 5
);
    logic [RAM_WIDTH-1:0] din;
    logic                 write_enb;
    logic                 lfd_state;
    logic                 read_enb;
    logic [RAM_WIDTH-1:0] data_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic [ADDR_SIZE-1:0] fill_level;
    logic                 pkt_done;
    logic                 overflow;
    logic                 parity_err;

    modport master (
        output din, write_enb, lfd_state, read_enb,
        input  data_out, full, empty, almost_full, fill_level, pkt_done, overflow, parity_err
    );

    modport slave (
        input  din, write_enb, lfd_state, read_enb,
        output data_out, full, empty, almost_full, fill_level, pkt_done, overflow, parity_err
    );
endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: stores {lfd, byte}, tracks packet ends on the read side.
// Optional parity checking of popped packets is enabled by defining ROUTER_FIFO_PARITY_CHK_EN.
module router_fifo_pkt #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16,
    parameter int ADDR_SIZE = 5,
    parameter int AF_LEVEL  = 14
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    router_fifo_pkt_if.slave bus
);
    localparam int IDX_W = ADDR_SIZE - 1;
    localparam int CNT_W = RAM_WIDTH - 1;
    localparam logic [ADDR_SIZE-1:0] AF_LVL = AF_LEVEL[ADDR_SIZE-1:0];

    typedef struct packed {
        logic                 lfd;
        logic [RAM_WIDTH-1:0] data;
    } entry_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] wr_ptr;
        logic [ADDR_SIZE-1:0] rd_ptr;
        logic [ADDR_SIZE-1:0] fill_level;
        logic [CNT_W-1:0]     rd_count;
        logic [RAM_WIDTH-1:0] data_out;
        logic                 full;
        logic                 empty;
        logic                 almost_full;
        logic                 pkt_done;
        logic                 overflow;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{empty: 1'b1, default: '0};

    entry_t               mem [RAM_DEPTH];
    entry_t               rd_entry;
    ctrl_t                ctrl;
    ctrl_t                ctrl_nxt;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 last_pop;
    logic [ADDR_SIZE-1:0] wr_ptr_nxt;
    logic [ADDR_SIZE-1:0] rd_ptr_nxt;

    // Acceptance uses the registered flags, which always match the current pointers.
    assign wr_ok      = bus.write_enb && !ctrl.full;
    assign rd_ok      = bus.read_enb && !ctrl.empty;
    assign rd_entry   = mem[ctrl.rd_ptr[IDX_W-1:0]];
    assign last_pop   = rd_ok && !rd_entry.lfd && (ctrl.rd_count == CNT_W'(1));
    assign wr_ptr_nxt = ctrl.wr_ptr + ADDR_SIZE'(wr_ok);
    assign rd_ptr_nxt = ctrl.rd_ptr + ADDR_SIZE'(rd_ok);

    always_comb begin
        // NOTE: start from the current value so every path assigns every field (no latch).
        ctrl_nxt             = ctrl;
        ctrl_nxt.wr_ptr      = wr_ptr_nxt;
        ctrl_nxt.rd_ptr      = rd_ptr_nxt;
        ctrl_nxt.fill_level  = wr_ptr_nxt - rd_ptr_nxt;
        ctrl_nxt.full        = (wr_ptr_nxt[IDX_W] != rd_ptr_nxt[IDX_W]) &&
                               (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]);
        ctrl_nxt.empty       = (wr_ptr_nxt == rd_ptr_nxt);
        ctrl_nxt.almost_full = ((wr_ptr_nxt - rd_ptr_nxt) >= AF_LVL);
        ctrl_nxt.pkt_done    = last_pop;
        if (bus.write_enb && ctrl.full) begin
            ctrl_nxt.overflow = 1'b1;
        end
        if (rd_ok) begin
            ctrl_nxt.data_out = rd_entry.data;
            // A header always reloads, which silently abandons a truncated packet.
            if (rd_entry.lfd) begin
                ctrl_nxt.rd_count = {1'b0, rd_entry.data[RAM_WIDTH-1:2]} + CNT_W'(1);
            end else if (ctrl.rd_count != '0) begin
                ctrl_nxt.rd_count = ctrl.rd_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!resetn) begin
            ctrl <= CTRL_RST;
        end else if (soft_reset) begin
            ctrl <= CTRL_RST;
        end else begin
            ctrl <= ctrl_nxt;
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[ctrl.wr_ptr[IDX_W-1:0]] <= '{lfd: bus.lfd_state, data: bus.din};
        end
    end

    assign bus.data_out    = ctrl.data_out;
    assign bus.full        = ctrl.full;
    assign bus.empty       = ctrl.empty;
    assign bus.almost_full = ctrl.almost_full;
    assign bus.fill_level  = ctrl.fill_level;
    assign bus.pkt_done    = ctrl.pkt_done;
    assign bus.overflow    = ctrl.overflow;

`ifdef ROUTER_FIFO_PARITY_CHK_EN
    logic [RAM_WIDTH-1:0] run_xor;
    logic                 parity_err_q;

    // The header seeds the running XOR; the final byte is compared, not folded in.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run_xor      <= '0;
            parity_err_q <= 1'b0;
        end else if (soft_reset) begin
            run_xor      <= '0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= last_pop && (run_xor != rd_entry.data);
            if (rd_ok && rd_entry.lfd) begin
                run_xor <= rd_entry.data;
            end else if (rd_ok && !last_pop) begin
                run_xor <= run_xor ^ rd_entry.data;
            end
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_fifo_pkt.sv
// Self-checking bench for router_fifo_pkt: directed table, corner sequences, and
// randomized traffic against a queue-based packet model.
module tb_router_fifo_pkt;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int AF    = 14;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clock      = 1'b0;
    logic resetn     = 1'b0;
    logic soft_reset = 1'b0;

    always #5 clock = ~clock;

    router_fifo_pkt_if #(.RAM_WIDTH(W), .ADDR_SIZE(AW)) bus ();

    router_fifo_pkt #(
        .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_SIZE(AW), .AF_LEVEL(AF)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .soft_reset(soft_reset),
        .bus(bus.slave)
    );

    typedef struct {
        bit         we;
        bit         lfd;
        logic [7:0] din;
        bit         re;
        logic [7:0] e_dout;
        bit         e_empty;
        logic [4:0] e_fill;
        bit         e_pd;
        bit         e_pe;
    } vec_t;

    // Reference model: a queue of {lfd, byte} plus packet bookkeeping for popped bytes.
    logic [8:0] q[$];
    logic [7:0] m_dout;
    logic [7:0] m_xor;
    logic       m_ovf, m_pd, m_pe;
    int         m_left;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [18:0] dut_vec();
        return {bus.data_out, bus.full, bus.empty, bus.almost_full, bus.fill_level,
                bus.pkt_done, bus.overflow, bus.parity_err};
    endfunction

    function automatic logic [18:0] model_vec();
        return {m_dout, q.size() == DEPTH, q.size() == 0, q.size() >= AF, 5'(q.size()),
                m_pd, m_ovf, m_pe};
    endfunction

    function automatic vec_t mk(bit we, bit lfd, logic [7:0] din, bit re, logic [7:0] dout,
                                bit empty, logic [4:0] fill, bit pd, bit pe);
        vec_t v;
        v.we = we; v.lfd = lfd; v.din = din; v.re = re; v.e_dout = dout;
        v.e_empty = empty; v.e_fill = fill; v.e_pd = pd; v.e_pe = pe;
        return v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_dout = '0; m_xor = '0; m_ovf = 1'b0; m_pd = 1'b0; m_pe = 1'b0; m_left = 0;
    endtask

    task automatic model_pop(input logic [8:0] e);
        m_dout = e[7:0];
        if (e[8]) begin
            m_left = int'(e[7:2]) + 1;
            m_xor  = e[7:0];
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_pd = 1'b1;
                m_pe = PAR_EN && (m_xor != e[7:0]);
            end else begin
                m_xor = m_xor ^ e[7:0];
            end
        end
    endtask

    task automatic model_step(input bit we, input bit lfd, input logic [7:0] d,
                              input bit re, input bit sr);
        bit w_ok, r_ok;
        m_pd = 1'b0;
        m_pe = 1'b0;
        if (sr) begin
            model_clear();
            return;
        end
        w_ok = we && (q.size() < DEPTH);
        r_ok = re && (q.size() > 0);
        if (we && q.size() == DEPTH) m_ovf = 1'b1;
        if (r_ok) model_pop(q.pop_front());
        if (w_ok) q.push_back({lfd, d});
    endtask

    // One clock: drive inputs, take the edge, advance the model, return the bus to idle.
    task automatic cyc(input bit we, input bit lfd, input logic [7:0] d, input bit re, input bit sr);
        bus.write_enb = we; bus.lfd_state = lfd; bus.din = d; bus.read_enb = re; soft_reset = sr;
        @(posedge clock);
        #1;
        model_step(we, lfd, d, re, sr);
        bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.read_enb = 1'b0; soft_reset = 1'b0;
    endtask

    task automatic step_chk(input string name);
        check(name, dut_vec(), model_vec());
    endtask

    vec_t tbl[18];

    initial begin
        logic [7:0] b, px;
        int         n_wr, pd_seen;

        bus.din = '0; bus.write_enb = 1'b0; bus.lfd_state = 1'b0; bus.read_enb = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        step_chk("reset_state");
        resetn = 1'b1;

        // Packet 09 A5 5A F6 (len 2, good parity), then the same packet with parity 00.
        tbl[0]  = mk(1, 1, 8'h09, 0, 8'h00, 0, 5'd1, 0, 0);
        tbl[1]  = mk(1, 0, 8'hA5, 0, 8'h00, 0, 5'd2, 0, 0);
        tbl[2]  = mk(1, 0, 8'h5A, 0, 8'h00, 0, 5'd3, 0, 0);
        tbl[3]  = mk(1, 0, 8'hF6, 0, 8'h00, 0, 5'd4, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1, 8'h09, 0, 5'd3, 0, 0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 8'hA5, 0, 5'd2, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 1, 8'h5A, 0, 5'd1, 0, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 8'hF6, 1, 5'd0, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 8'hF6, 1, 5'd0, 0, 0);
        tbl[9]  = mk(1, 1, 8'h09, 0, 8'hF6, 0, 5'd1, 0, 0);
        tbl[10] = mk(1, 0, 8'hA5, 0, 8'hF6, 0, 5'd2, 0, 0);
        tbl[11] = mk(1, 0, 8'h5A, 0, 8'hF6, 0, 5'd3, 0, 0);
        tbl[12] = mk(1, 0, 8'h00, 0, 8'hF6, 0, 5'd4, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 1, 8'h09, 0, 5'd3, 0, 0);
        tbl[14] = mk(0, 0, 8'h00, 1, 8'hA5, 0, 5'd2, 0, 0);
        tbl[15] = mk(0, 0, 8'h00, 1, 8'h5A, 0, 5'd1, 0, 0);
        tbl[16] = mk(0, 0, 8'h00, 1, 8'h00, 1, 5'd0, 1, PAR_EN);
        tbl[17] = mk(0, 0, 8'h00, 0, 8'h00, 1, 5'd0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re, 1'b0);
            check($sformatf("tbl[%0d]", i),
                  {bus.data_out, bus.empty, bus.fill_level, bus.pkt_done, bus.parity_err},
                  {tbl[i].e_dout, tbl[i].e_empty, tbl[i].e_fill, tbl[i].e_pd, tbl[i].e_pe});
        end

        // Async reset asserted mid-cycle while a write is pending.
        cyc(1, 1, 8'h21, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        bus.write_enb = 1'b1; bus.din = 8'h77;
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst", dut_vec(), {8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clock);
        #1;
        check("rst_next", dut_vec(), {8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        bus.write_enb = 1'b0;
        resetn = 1'b1;
        model_clear();

        // 17 writes of a len-15 packet: the parity byte hits a full FIFO and is dropped.
        cyc(1, 1, 8'h3D, 0, 0);
        step_chk("t2_wr0");
        px = 8'h3D;
        for (int i = 1; i < 17; i++) begin
            b = (i == 16) ? px : 8'($urandom_range(0, 255));
            if (i < 16) px = px ^ b;
            cyc(1, 0, b, 0, 0);
            step_chk($sformatf("t2_wr%0d", i));
            if (i == 12) check("t2_af_13", bus.almost_full, 1'b0);
            if (i == 13) check("t2_af_14", bus.almost_full, 1'b1);
            if (i == 15) check("t2_full_16", bus.full, 1'b1);
        end
        check("t2_ovf", {bus.overflow, bus.fill_level}, {1'b1, 5'd16});
        pd_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            step_chk($sformatf("t2_rd%0d", i));
            pd_seen += int'(bus.pkt_done);
        end
        check("t2_empty", bus.empty, 1'b1);
        check("t2_no_pd", pd_seen, 0);

        // Soft reset clears sticky overflow; then streaming at a constant fill level.
        cyc(1, 0, 8'h55, 0, 0);
        cyc(0, 0, 8'h00, 0, 1);
        check("srst_ovf", bus.overflow, 1'b0);
        step_chk("t4_srst");
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0);
            step_chk($sformatf("t4_fill%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 1, 0);
            step_chk($sformatf("t4_rw%0d", i));
            check($sformatf("t4_lvl%0d", i), bus.fill_level, 5'd8);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0);
            step_chk($sformatf("t4_top%0d", i));
        end
        cyc(1, 0, 8'hAB, 1, 0);
        step_chk("t4_full_rw");
        check("t4_full_rw_st", {bus.overflow, bus.fill_level}, {1'b1, 5'd15});

        // Soft reset in the middle of a packet, then a fresh packet must complete.
        cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 1, 8'h0D, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h30 + i), 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        step_chk("t5_mid");
        cyc(0, 0, 8'h00, 0, 1);
        check("t5_srst", {bus.empty, bus.fill_level, bus.overflow, bus.pkt_done},
              {1'b1, 5'd0, 1'b0, 1'b0});
        cyc(1, 1, 8'h05, 0, 0);
        cyc(1, 0, 8'h11, 0, 0);
        cyc(1, 0, 8'h14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            step_chk($sformatf("t5_rd%0d", i));
        end
        check("t5_pd", {bus.pkt_done, bus.parity_err}, {1'b1, 1'b0});

        // Truncated packet: a new header mid-packet restarts the count, one pkt_done total.
        cyc(1, 1, 8'h09, 0, 0);
        cyc(1, 0, 8'hAA, 0, 0);
        cyc(1, 1, 8'h05, 0, 0);
        cyc(1, 0, 8'h11, 0, 0);
        cyc(1, 0, 8'h14, 0, 0);
        pd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            step_chk($sformatf("trunc_rd%0d", i));
            pd_seen += int'(bus.pkt_done);
        end
        check("trunc_pd_count", pd_seen, 1);

        // 40 bytes in alternating bursts of three writes and three reads (pointer wrap).
        cyc(0, 0, 8'h00, 0, 1);
        n_wr = 0;
        while (n_wr < 40) begin
            for (int i = 0; i < 3 && n_wr < 40; i++) begin
                cyc(1, 0, 8'($urandom_range(0, 255)), 0, 0);
                n_wr++;
                step_chk($sformatf("t6_wr%0d", n_wr));
            end
            for (int i = 0; i < 3; i++) begin
                cyc(0, 0, 8'h00, 1, 0);
                step_chk($sformatf("t6_rd%0d", n_wr));
            end
        end

        // Random mixed traffic: random headers, bursts, occasional soft reset.
        for (int i = 0; i < 400; i++) begin
            bit we, lfd, re, sr;
            we  = ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 2) != 0);
            lfd = ($urandom_range(0, 5) == 0);
            sr  = ($urandom_range(0, 49) == 0);
            cyc(we, lfd, 8'($urandom_range(0, 255)), re, sr);
            step_chk($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
